// File: rtl/zero_out_pkg.sv
// Shared types and helpers for the output-channel FIFO slice.
// The overwrite ring mode is selected with OUT_CHANNEL_OVERWRITE_EN.
package zero_out_pkg;

    localparam int DefMemoryElementWidth = 12;
    localparam int DefCountWidth         = 16;

    typedef logic [DefMemoryElementWidth-1:0] out_elem_t;
    typedef logic [DefCountWidth-1:0]         out_stat_t;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic out_stat_t sat_inc(input out_stat_t v);
        return (v == {DefCountWidth{1'b1}}) ? v : v + {{(DefCountWidth-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/out_channel_ptr.sv
// Modulo-Depth ring pointer with advance enable; Depth need not be a power of two.
module out_channel_ptr
    import zero_out_pkg::*;
#(
    parameter int Depth = 4,
    parameter int PW    = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_en,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;

    // Pointer register: wraps from Depth-1 back to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= {PW{1'b0}};
        end else if (i_en) begin
            r_ptr <= (r_ptr == PW'(Depth - 1)) ? {PW{1'b0}} : r_ptr + PW'(1);
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/out_channel_fifo.sv
// Back-pressured output channel for `out` values; first-word-fall-through pop port.
// Define OUT_CHANNEL_OVERWRITE_EN for oldest-element-lost ring behaviour when full.
module out_channel_fifo
    import zero_out_pkg::*;
#(
    parameter int MemoryElementWidth = DefMemoryElementWidth,
    parameter int NOut               = 4,
    parameter int CountWidth         = DefCountWidth,
    parameter int CW                 = $clog2(NOut + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push_valid,
    input  logic [MemoryElementWidth-1:0] push_data,
    output logic                          push_ready,
    output logic                          pop_valid,
    output logic [MemoryElementWidth-1:0] pop_data,
    input  logic                          pop_ready,
    input  logic                          program_done,
    output logic [CW-1:0]                 count,
    output logic [CountWidth-1:0]         total_pushed,
    output logic [CountWidth-1:0]         dropped,
    output logic                          drained
);

    localparam int PW = (NOut > 1) ? $clog2(NOut) : 1;

    logic [MemoryElementWidth-1:0] r_mem [NOut];
    logic [CW-1:0]                 r_count;
    out_stat_t                     r_total;
    logic                          r_done_seen;
    logic                          r_drained;
    logic [PW-1:0]                 w_wr_ptr;
    logic [PW-1:0]                 w_rd_ptr;
    logic                          w_push_acc;
    logic                          w_pop_acc;
    logic                          w_drop;
    logic                          w_rd_en;
    logic                          w_full;

    assign w_full     = (r_count == CW'(NOut));
    assign pop_valid  = (r_count != {CW{1'b0}});
    assign pop_data   = r_mem[w_rd_ptr];
    assign w_push_acc = push_valid && push_ready;
    assign w_pop_acc  = pop_valid && pop_ready;

`ifdef OUT_CHANNEL_OVERWRITE_EN
    out_stat_t r_dropped;

    assign push_ready = 1'b1;
    // A push into a full ring with no pop evicts the oldest element.
    assign w_drop     = w_push_acc && w_full && !w_pop_acc;

    // Count of evicted elements.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dropped <= '0;
        end else if (w_drop) begin
            r_dropped <= sat_inc(r_dropped);
        end else begin
            r_dropped <= r_dropped;
        end
    end

    assign dropped = CountWidth'(r_dropped);
`else
    assign push_ready = !w_full;
    assign w_drop     = 1'b0;
    assign dropped    = {CountWidth{1'b0}};
`endif

    assign w_rd_en = w_pop_acc || w_drop;

    out_channel_ptr #(.Depth(NOut), .PW(PW)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .i_en  (w_push_acc),
        .o_ptr (w_wr_ptr)
    );

    out_channel_ptr #(.Depth(NOut), .PW(PW)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .i_en  (w_rd_en),
        .o_ptr (w_rd_ptr)
    );

    // Storage is deliberately left unreset; occupancy alone defines validity.
    always_ff @(posedge clock) begin
        if (w_push_acc) begin
            r_mem[w_wr_ptr] <= push_data;
        end
    end

    // Occupancy, push statistics, and drain tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count     <= {CW{1'b0}};
            r_total     <= '0;
            r_done_seen <= 1'b0;
            r_drained   <= 1'b0;
        end else begin
            if (w_push_acc && !w_pop_acc && !w_drop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_acc && !w_push_acc) begin
                r_count <= r_count - CW'(1);
            end else begin
                r_count <= r_count;
            end
            r_total     <= w_push_acc ? sat_inc(r_total) : r_total;
            r_done_seen <= r_done_seen || program_done;
            r_drained   <= r_done_seen && (r_count == {CW{1'b0}});
        end
    end

    assign count        = r_count;
    assign total_pushed = CountWidth'(r_total);
    assign drained      = r_drained;

endmodule
